// File: rtl/alu_pipe_if.sv
// alu_pipe_if: input and output valid/ready channels of alu_pipe.
// slave = ALU side; master = controller / write-back side.
// Input channel:  in_valid, in_ready, in_a, in_b, opcode.
// Output channel: out_valid, out_ready, alu_out, out_op, a_is_zero, carry.
interface alu_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       opcode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_out;
    logic [2:0]       out_op;
    logic             a_is_zero;
    logic             carry;

    modport slave (
        input  in_valid, in_a, in_b, opcode, out_ready,
        output in_ready, out_valid, alu_out, out_op, a_is_zero, carry
    );

    modport master (
        output in_valid, in_a, in_b, opcode, out_ready,
        input  in_ready, out_valid, alu_out, out_op, a_is_zero, carry
    );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined 8-op ALU with valid/ready backpressure,
// registered carry, optional saturating ADD and an HLT-driven halt state.
// Ports: clk, rst_n (sync, active-low), bus (alu_pipe_if.slave),
//        resume (pulse leaves halt), halted (halt state active).
module alu_pipe #(
    parameter int WIDTH   = 8,
    parameter int SAT_ADD = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_pipe_if.slave   bus,
    input  logic        resume,
    output logic        halted
);
    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_op;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_res;
    logic [2:0]       s2_op;
    logic             s2_az;
    logic             s2_carry;

    logic s2_adv;
    logic s1_adv;
    logic accept;
    logic hlt_accept;

    // Ready chain runs from the output back to the input.
    assign s2_adv     = !s2_valid || bus.out_ready;
    assign s1_adv     = !s1_valid || s2_adv;
    assign bus.in_ready = s1_adv && !halted;
    assign accept     = bus.in_valid && bus.in_ready;
    assign hlt_accept = accept && (bus.opcode == OP_HLT);

    logic is_add;
    logic is_and;
    logic is_xor;
    logic is_lda;

    assign is_add = (s1_op == OP_ADD);
    assign is_and = (s1_op == OP_AND);
    assign is_xor = (s1_op == OP_XOR);
    assign is_lda = (s1_op == OP_LDA);

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res;
    logic             res_carry;

    always_comb begin
        sum       = {1'b0, s1_a} + {1'b0, s1_b};
        res       = s1_a;
        res_carry = 1'b0;
        unique case (1'b1)
            is_add: begin
                res_carry = sum[WIDTH];
                // Saturation clamps the value but still reports carry.
                if ((SAT_ADD != 0) && sum[WIDTH]) begin
                    res = '1;
                end else begin
                    res = sum[WIDTH-1:0];
                end
            end
            is_and:  res = s1_a & s1_b;
            is_xor:  res = s1_a ^ s1_b;
            is_lda:  res = s1_b;
            default: res = s1_a;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
            s2_valid <= 1'b0;
            s2_res   <= '0;
            s2_op    <= '0;
            s2_az    <= 1'b0;
            s2_carry <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= accept;
            end
            if (accept) begin
                s1_a  <= bus.in_a;
                s1_b  <= bus.in_b;
                s1_op <= bus.opcode;
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
            end
            // Result registers only change on a real transfer so the
            // outputs keep their last values while idle or stalled.
            if (s2_adv && s1_valid) begin
                s2_res   <= res;
                s2_op    <= s1_op;
                s2_az    <= (s1_a == '0);
                s2_carry <= res_carry;
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.alu_out   = s2_res;
    assign bus.out_op    = s2_op;
    assign bus.a_is_zero = s2_az;
    assign bus.carry     = s2_carry;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // An HLT accept only happens in RUN, where resume is ignored,
    // so HLT naturally wins over a coincident resume.
    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN:  if (hlt_accept) state_nxt = HALT;
            HALT: if (resume)     state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        halted = (state == HALT);
    end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, two-stage pipelined successor to the team's combinational 8-op ALU. It uses the same 3-bit opcode map and the same a_is_zero semantics, and adds the following:
- valid/ready handshakes on input and output, with full backpressure
- a registered carry flag
- an optional saturating ADD
- a HLT-driven halt state that blocks new input until a resume pulse
It sits between the VeriRISC-style controller/decoder and the accumulator/register write-back path.

Parameters:
WIDTH, 8, operand/result width in bits (>=2).
SAT_ADD, 0, 1 = ADD saturates to all-ones on carry-out; 0 = ADD wraps modulo 2^WIDTH.

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  synchronous reset, active-low
in_valid  input  1  operand/opcode presented
in_ready  output  1  block can accept this cycle
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
opcode  input  3  000 HLT, 001 SKZ, 010 ADD, 011 AND, 100 XOR, 101 LDA, 110 STO, 111 JMP
resume  input  1  single-cycle pulse clears halt state
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
alu_out  output  WIDTH  result
out_op  output  3  opcode of the transaction on the output
a_is_zero  output  1  in_a of this transaction was zero
carry  output  1  carry-out of ADD; 0 for all other ops
halted  output  1  halt state active

Behaviour:
- Reset (rst_n low at a clock edge) clears the following, and the flush takes priority over everything else that cycle:
  - s1_valid and s2_valid to 0
  - out_valid, alu_out, out_op, a_is_zero, carry and halted to 0
  - Reset mid-transaction discards all in-flight transactions; no result is emitted for them.
- Stage S1: registers in_a, in_b, opcode on input accept (in_valid && in_ready).
- Stage S2: computes from the S1 registers and registers the result, out_op, a_is_zero and carry. The S2 registers drive the outputs directly, with no combinational path from in_* to out_*.
- Opcode results:
  - HLT, SKZ, STO, JMP → A
  - ADD → A+B
  - AND → A&B
  - XOR → A^B
  - LDA → B
- ADD arithmetic: computed at WIDTH+1 bits; carry = bit WIDTH.
  - SAT_ADD=1 and carry=1: alu_out = all ones, and carry still reports 1.
  - SAT_ADD=0: alu_out = low WIDTH bits (wrap-around).
- a_is_zero = (in_a == 0) for the transaction, carried through the pipe; it is not live.
- Latency: 2 cycles from input accept to out_valid when unstalled. Throughput is 1 transaction per cycle.
- Ready chain:
  - s2_adv = !s2_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv && !halted (combinational; no dependency on in_valid)
- Stall: while out_valid && !out_ready, the outputs hold stable and S1 holds. in_ready drops once S1 is also full. No transaction is lost or duplicated.
- Simultaneous events: in the same cycle, S2 may drain to the output, S1 may move to S2, and a new input may load S1.
- out_valid = s2_valid. Outputs are don't-care-but-stable when out_valid is 0; the implementation keeps the last values.
- Halt state machine, two states:
  - RUN → HALT when an HLT-opcode transaction is accepted at the input. halted=1 from the next cycle, which forces in_ready=0.
  - Transactions already in the pipeline, including the HLT itself, drain normally.
  - HALT → RUN on resume=1 at a clock edge. in_ready may rise the following cycle.
  - resume in RUN is ignored.
  - If resume and an HLT accept occur in the same cycle, the HLT wins (halted=1).

Test Plan:
- Reset/idle: rst_n=0 for 2 cycles with in_valid=1 → out_valid=0, halted=0, carry=0. in_ready=1 after release.
- Back-to-back unstalled, WIDTH=8: ADD 0x0F+0x01, XOR 0xF0^0xFF, LDA B=0x5A, one per cycle, out_ready=1 → out_valid on cycles 2, 3, 4 after first accept. Expected alu_out 0x10, 0x0F, 0x5A; carry all 0.
- Carry/saturation: ADD 0xFF+0x02 → SAT_ADD=0 gives 0x01, carry=1. SAT_ADD=1 gives 0xFF, carry=1. AND 0x00&0x33 → 0x00, a_is_zero=1, carry=0.
- Backpressure: out_ready=0 for 5 cycles while feeding 4 transactions →
  - in_ready falls after the 2nd accept.
  - Outputs stay stable throughout the stall.
  - Releasing out_ready delivers the results in order with no loss or duplication (4 results total).
- Halt: HLT A=0x00 then in_valid held with ADD →
  - in_ready=0 the cycle after the HLT accept.
  - HLT emerges with alu_out=0x00, a_is_zero=1, halted=1.
  - resume pulse → ADD accepted the next cycle.
  - HLT accept coinciding with a resume pulse → halted=1.
- Reset mid-flight: 2 transactions in the pipe plus halted=1, then rst_n=0 for 1 cycle → no out_valid for the flushed transactions, halted=0, and a new input is accepted the cycle after release.
